// File: rtl/cipher_pkg.sv
// Shared constants for the cipher front-end: channel selects, start token, demux states.
package cipher_pkg;

  localparam logic [1:0] SEL_CAESAR  = 2'd0;
  localparam logic [1:0] SEL_SCYTALE = 2'd1;
  localparam logic [1:0] SEL_ZIGZAG  = 2'd2;
  localparam logic [1:0] SEL_RSVD    = 2'd3;

  localparam logic [7:0] START_TOKEN = 8'hFA;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

endpackage

// File: rtl/cipher_demux.sv
// Unpacks 32-bit master words into bytes (MSB first) and routes them to the
// decryption core chosen by select_i, stalling on that core's busy flag and
// inserting a one-cycle bubble after every start token.
module cipher_demux #(
  parameter int              MST_DWIDTH  = 32,
  parameter int              SYS_DWIDTH  = 8,
  parameter logic [7:0]      START_TOKEN = 8'hFA
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [MST_DWIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [1:0]            select_i,
  input  logic                  busy0_i,
  input  logic                  busy1_i,
  input  logic                  busy2_i,
  output logic [SYS_DWIDTH-1:0] data0_o,
  output logic                  valid0_o,
  output logic [SYS_DWIDTH-1:0] data1_o,
  output logic                  valid1_o,
  output logic [SYS_DWIDTH-1:0] data2_o,
  output logic                  valid2_o
);

  import cipher_pkg::*;

  localparam int NBYTES = MST_DWIDTH / SYS_DWIDTH;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  last_q, last_d;
  logic [MST_DWIDTH-1:0] word_q, word_d;
  logic [1:0]            sel_q, sel_d;
  logic                  ready_q, ready_d;
  logic [SYS_DWIDTH-1:0] data0_q, data0_d, data1_q, data1_d, data2_q, data2_d;
  logic                  valid0_q, valid0_d, valid1_q, valid1_d, valid2_q, valid2_d;

  logic [SYS_DWIDTH-1:0] cur_byte;
  logic                  busy_sel;
  logic                  idx_last;

  // Current byte of the latched word (byte 0 is the most significant) and busy of the selected core.
  always_comb begin
    cur_byte = word_q[MST_DWIDTH - 1 - SYS_DWIDTH * int'(idx_q) -: SYS_DWIDTH];
    idx_last = (idx_q == LAST_IDX);
    case (sel_q)
      SEL_CAESAR:  busy_sel = busy0_i;
      SEL_SCYTALE: busy_sel = busy1_i;
      SEL_ZIGZAG:  busy_sel = busy2_i;
      default:     busy_sel = 1'b1;
    endcase
  end

  // Next-state logic: accept in IDLE, launch bytes in SEND, one bubble cycle in GAP.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    word_d   = word_q;
    sel_d    = sel_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    valid0_d = 1'b0;
    valid1_d = 1'b0;
    valid2_d = 1'b0;
    case (state_q)
      IDLE: begin
        // A reserved select consumes the word without producing anything.
        if (valid_i && ready_q && (select_i != SEL_RSVD)) begin
          word_d  = data_i;
          sel_d   = select_i;
          idx_d   = '0;
          last_d  = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!busy_sel) begin
          case (sel_q)
            SEL_CAESAR:  begin data0_d = cur_byte; valid0_d = 1'b1; end
            SEL_SCYTALE: begin data1_d = cur_byte; valid1_d = 1'b1; end
            SEL_ZIGZAG:  begin data2_d = cur_byte; valid2_d = 1'b1; end
            default:     ;
          endcase
          // idx parks on the last byte; the state change ends the word instead of a wrap.
          idx_d  = idx_last ? idx_q : idx_q + 1'b1;
          last_d = idx_last;
          if (cur_byte == START_TOKEN[SYS_DWIDTH-1:0]) begin
            state_d = GAP;
          end else if (idx_last) begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        // Gives the core one edge to raise busy after seeing the token.
        state_d = last_q ? IDLE : SEND;
      end
      default: state_d = IDLE;
    endcase
    // Ready only once the FSM has settled in IDLE, so a word never lands on the finishing edge.
    ready_d = (state_q == IDLE) && (state_d == IDLE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      last_q   <= 1'b0;
      word_q   <= '0;
      sel_q    <= SEL_CAESAR;
      ready_q  <= 1'b1;
      data0_q  <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      word_q   <= word_d;
      sel_q    <= sel_d;
      ready_q  <= ready_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      valid2_q <= valid2_d;
    end
  end

  assign ready_o  = ready_q;
  assign data0_o  = data0_q;
  assign data1_o  = data1_q;
  assign data2_o  = data2_q;
  assign valid0_o = valid0_q;
  assign valid1_o = valid1_q;
  assign valid2_o = valid2_q;

endmodule

// File: tb/tb_cipher_demux.sv
// Directed bench for cipher_demux: reset, plain word, token bubble, stall, reserved select, reset mid-word.
module tb_cipher_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  select_i;
  logic        busy0_i, busy1_i, busy2_i;
  logic [7:0]  data0_o, data1_o, data2_o;
  logic        valid0_o, valid1_o, valid2_o;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] scy_cnt;

  cipher_demux dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .select_i (select_i),
    .busy0_i  (busy0_i),
    .busy1_i  (busy1_i),
    .busy2_i  (busy2_i),
    .data0_o  (data0_o),
    .valid0_o (valid0_o),
    .data1_o  (data1_o),
    .valid1_o (valid1_o),
    .data2_o  (data2_o),
    .valid2_o (valid2_o)
  );

  always #5 clk = ~clk;

  // Scytale core model: busy rises the edge after it sees the token, held for 6 cycles.
  always @(posedge clk) begin
    if (rst_n)                                scy_cnt <= 4'd0;
    else if (valid1_o && data1_o == 8'hFA)    scy_cnt <= 4'd6;
    else if (scy_cnt != 4'd0)                 scy_cnt <= scy_cnt - 4'd1;
  end
  assign busy1_i = (scy_cnt != 4'd0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [1:0] s);
    data_i   = w;
    select_i = s;
    valid_i  = 1'b1;
    tick();
    valid_i  = 1'b0;
  endtask

  logic [31:0] w1 = 32'h41424344;
  logic        tok_v [12] = '{1,1,1,0,0,0,0,0,0,0,1,0};
  logic [7:0]  tok_d [12] = '{8'h48,8'h45,8'hFA,8'hFA,8'hFA,8'hFA,8'hFA,8'hFA,8'hFA,8'hFA,8'h4C,8'h4C};

  initial begin
    rst_n = 1'b1; valid_i = 1'b0; data_i = '0; select_i = 2'd0;
    busy0_i = 1'b0; busy2_i = 1'b0;
    tick(); tick();
    chk("rst_ready", ready_o, 1);
    chk("rst_v0", valid0_o, 0);
    chk("rst_v1", valid1_o, 0);
    chk("rst_v2", valid2_o, 0);
    chk("rst_d0", data0_o, 0);
    chk("rst_d1", data1_o, 0);
    chk("rst_d2", data2_o, 0);
    rst_n = 1'b0;
    tick();

    // Plain word on caesar
    send_word(w1, 2'd0);
    chk("w1_ready_k", ready_o, 0);
    chk("w1_v0_k", valid0_o, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("w1_v0", valid0_o, 1);
      chk("w1_d0", data0_o, 32'(w1[31-8*i -: 8]));
      chk("w1_v1", valid1_o, 0);
      chk("w1_v2", valid2_o, 0);
      chk("w1_ready", ready_o, 0);
    end
    tick();
    chk("w1_ready_k5", ready_o, 1);
    chk("w1_v0_k5", valid0_o, 0);
    chk("w1_d1_hold", data1_o, 0);

    // Token bubble on scytale
    send_word(32'h4845FA4C, 2'd1);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("tok_v1", valid1_o, 32'(tok_v[i]));
      chk("tok_d1", data1_o, 32'(tok_d[i]));
      chk("tok_v0", valid0_o, 0);
      chk("tok_ready", ready_o, (i == 11) ? 1 : 0);
    end

    // Stall on zigzag
    busy2_i = 1'b1;
    send_word(32'h11223344, 2'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_v2", valid2_o, 0);
      chk("stall_d2", data2_o, 0);
    end
    busy2_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_v2_run", valid2_o, 1);
      chk("stall_d2_run", data2_o, 32'(8'h11 * (i + 1)));
    end
    tick();
    chk("stall_ready", ready_o, 1);

    // Reserved select drops the word
    send_word(32'hDEADBEEF, 2'd3);
    for (int i = 0; i < 3; i++) begin
      chk("rsvd_ready", ready_o, 1);
      chk("rsvd_v", {29'd0, valid2_o, valid1_o, valid0_o}, 0);
      tick();
    end
    send_word(32'h10203040, 2'd0);
    chk("next_ready", ready_o, 0);
    tick();
    chk("next_v0", valid0_o, 1);
    chk("next_d0", data0_o, 32'h10);
    tick(); tick(); tick();
    chk("next_d0_last", data0_o, 32'h40);
    tick();
    chk("next_ready_back", ready_o, 1);

    // Reset in the middle of a word
    send_word(32'h51525354, 2'd0);
    tick();
    chk("mid_b0", data0_o, 32'h51);
    tick();
    chk("mid_b1", data0_o, 32'h52);
    rst_n = 1'b1;
    tick();
    chk("mid_v0", valid0_o, 0);
    chk("mid_ready", ready_o, 1);
    chk("mid_d0", data0_o, 0);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_after_v0", valid0_o, 0);
      chk("mid_after_ready", ready_o, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
